gsim_host: RTL

- Host-side counterpart of the Gauss-Seidel solver interface. It owns the 16-entry b vector, streams it to the solver on the in_en/b_in bus and waits for the solver's out_valid/x_out burst.
- It captures the 16 results into a readable buffer and flags protocol faults (timeout, broken output burst).
- It sits between the system configuration logic and the solver core.

---
 rtl/gsim_pkg.sv | 11 +
 rtl/gsim_result_buf.sv | 26 ++
 rtl/gsim_host.sv | 138 +++++++++++++
 3 files changed

// File: rtl/gsim_pkg.sv
// gsim_pkg: shared sizes and FSM encoding for the Gauss-Seidel host/solver pair.
package gsim_pkg;
    localparam int N = 16;
    localparam int B_W = 16;
    localparam int X_W = 32;
    localparam int TIMEOUT_CYC = 8192;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam int SUM_W = X_W + 4;
    typedef enum logic [1:0] {IDLE, SEND, WAIT, COLLECT} state_t;
endpackage

// File: rtl/gsim_result_buf.sv
// gsim_result_buf: N x X_W result register file, one write port, registered read port.
module gsim_result_buf
    import gsim_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [X_W-1:0]   wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [X_W-1:0]   rdata
);
    logic [X_W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/gsim_host.sv
// gsim_host: streams the b vector to the solver, captures its x burst and flags protocol faults.
module gsim_host
    import gsim_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [B_W-1:0]   cfg_wdata,
    input  logic             start,
    input  logic [3:0]       rd_addr,
    output logic [X_W-1:0]   rd_data,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_burst,
    output logic [SUM_W-1:0] sum_x,
    output logic             gs_in_en,
    output logic [B_W-1:0]   gs_b,
    input  logic             gs_out_valid,
    input  logic [X_W-1:0]   gs_x
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [B_W-1:0]   b_mem [N];
    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             done_n, err_timeout_n, err_burst_n, x_we, gs_in_en_n;
    logic [SUM_W-1:0] sum_n, x_ext;
    logic [B_W-1:0]   gs_b_n;

    assign busy = state != IDLE;
    assign x_ext = {{(SUM_W - X_W){gs_x[X_W-1]}}, gs_x};

    always_ff @(posedge clk) begin
        if (!reset && cfg_we && state == IDLE)
            b_mem[cfg_addr] <= cfg_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            done <= 1'b0;
            err_timeout <= 1'b0;
            err_burst <= 1'b0;
            sum_x <= '0;
            gs_in_en <= 1'b0;
            gs_b <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            cnt <= cnt_n;
            done <= done_n;
            err_timeout <= err_timeout_n;
            err_burst <= err_burst_n;
            sum_x <= sum_n;
            gs_in_en <= gs_in_en_n;
            gs_b <= gs_b_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n = idx;
        cnt_n = cnt;
        done_n = done;
        err_timeout_n = err_timeout;
        err_burst_n = err_burst;
        sum_n = sum_x;
        x_we = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = SEND;
                idx_n = '0;
                done_n = 1'b0;
                err_timeout_n = 1'b0;
                err_burst_n = 1'b0;
                sum_n = '0;
            end
            SEND: if (idx == LAST) begin
                state_n = WAIT;
                idx_n = '0;
                cnt_n = '0;
            end else begin
                idx_n = idx + 1'b1;
            end
            WAIT: if (gs_out_valid) begin
                x_we = 1'b1;
                sum_n = sum_x + x_ext;
                idx_n = IDX_W'(1);
                state_n = COLLECT;
            end else if (cnt == TMO_LAST) begin
                err_timeout_n = 1'b1;
                done_n = 1'b1;
                state_n = IDLE;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            COLLECT: if (!gs_out_valid) begin
                err_burst_n = 1'b1;
                done_n = 1'b1;
                state_n = IDLE;
            end else begin
                x_we = 1'b1;
                sum_n = sum_x + x_ext;
                if (idx == LAST) begin
                    done_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A b write landing on the same edge as start is forwarded so the new value is sent first.
    always_comb begin
        gs_in_en_n = state_n == SEND;
        gs_b_n = !gs_in_en_n ? gs_b
               : (state == IDLE && cfg_we && cfg_addr == idx_n) ? cfg_wdata
               : b_mem[idx_n];
    end

    gsim_result_buf u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (x_we && !reset),
        .waddr (idx),
        .wdata (gs_x),
        .raddr (rd_addr),
        .rdata (rd_data)
    );
endmodule
